captura_operandos: RTL
======================

# captura_operandos

Sequential operand front-end for the generalized ALU. It captures two operands in turn from one shared data bus (board switches) on rising edges of a load button and drives them as registered `entrada_a`/`entrada_b` into the `Suma` adder. It also registers the adder's combinational `resultado` back for display, and marks with a one-cycle pulse when a fresh result is held.

## Interface
Parameters:
- `n_bits`, 8: operand, result and data-bus width.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `entrada_datos`  in  n_bits  operand value from switches; sampled only on a load edge.
- `boton_cargar`  in  1  load button, level (already debounced); only 0→1 transitions act.
- `boton_limpiar`  in  1  level, synchronous clear of the operand sequence.
- `resultado_suma`  in  n_bits  combinational sum returned from the adder.
- `entrada_a`  out  n_bits  registered operand A to adder.
- `entrada_b`  out  n_bits  registered operand B to adder.
- `resultado_reg`  out  n_bits  registered copy of `resultado_suma`.
- `valido`  out  1  high while both operands are loaded (state LISTO).
- `pulso_listo`  out  1  one-cycle pulse when `resultado_reg` takes a new value.
- `estado`  out  2  current state encoding, for LEDs: 00 ESPERA_A, 01 ESPERA_B, 10 LISTO.

## Operation
- Edge detect: `boton_prev` register; `flanco = boton_cargar & ~boton_prev`. `boton_prev` resets to 1, so a button held through reset release produces no edge.
- State ESPERA_A: on `flanco`, `entrada_a <= entrada_datos` → ESPERA_B.
- State ESPERA_B: on `flanco`, `entrada_b <= entrada_datos` → LISTO.
- State LISTO: holds operands. On `flanco`, starts a new pair: `entrada_a <= entrada_datos`, `entrada_b` unchanged, → ESPERA_B.
- Encoding 11 is unreachable. If it is ever entered, the next edge forces ESPERA_A.
- `boton_limpiar` high at an edge: → ESPERA_A, `entrada_a`, `entrada_b` and `resultado_reg` go to 0, `pulso_listo` goes to 0. It overrides a simultaneous `flanco`. `boton_prev` still updates normally.
- `reset` overrides everything, including `boton_limpiar`.
- Result capture: an internal flag `capturado` is cleared whenever the state enters LISTO. On the first edge in LISTO with `capturado`=0:
  - `resultado_reg <= resultado_suma`
  - `capturado <= 1`
  - `pulso_listo <= 1`
- At every other edge, `pulso_listo <= 0`.
- `resultado_reg` holds its value outside LISTO, so the last result stays displayed while the next pair is entered.
- Arithmetic: none in this block. Wrap-around of the sum is the adder's (modulo 2^n_bits). This block stores whatever `resultado_suma` presents.

## Timing
- Reset values (after the edge with `reset`=1):
  - `estado`=00, `entrada_a`=0, `entrada_b`=0, `resultado_reg`=0
  - `valido`=0, `pulso_listo`=0
  - `boton_prev`=1, `capturado`=0
- Load latency: `boton_cargar` first seen high at edge k → operand register updated and new `estado` visible after edge k.
- Holding the button for any number of cycles gives exactly one load.
- `valido` is `estado`==LISTO, registered. It rises after the B-load edge k and falls after the edge that leaves LISTO.
- Result latency: B loaded at edge k, so `resultado_suma` is settled during cycle k→k+1. `resultado_reg` updates at edge k+1, and `pulso_listo` is high for exactly cycle k+1→k+2.
- A load edge at k+1 (LISTO left immediately) takes precedence. No capture occurs, `pulso_listo` stays 0, and `resultado_reg` keeps its old value.
- `reset` or `boton_limpiar` mid-sequence (ESPERA_B or LISTO) aborts with no pulse.

## Test plan
- Basic pair: reset, then press with data 0x25, release, press with data 0x13. Expect `entrada_a`=0x25, `entrada_b`=0x13, `valido`=1 after the second edge. One cycle later `resultado_reg`=0x38, with `pulso_listo` high for exactly one cycle.
- Wrap-around: load 0xF0 then 0x20. Expect `resultado_reg`=0x10 and one pulse. Then press with 0x01 in LISTO. Expect `entrada_a`=0x01, `estado`=01, `valido`=0, `entrada_b`=0x20, and `resultado_reg` still 0x10.
- Held button: hold `boton_cargar` high 10 cycles with data 0x55, changing data to 0xAA mid-hold. Expect `entrada_a`=0x55 and `estado`=01 only (no B load).
- Clear priority: in ESPERA_B, assert `boton_limpiar` and a load edge at the same clock. Expect `estado`=00, all operands and `resultado_reg` 0, no pulse.
- Reset with button held: hold `boton_cargar`=1 across `reset` release. Expect no load until the button is released and pressed again. Reset mid-LISTO: all outputs return to their reset values after one edge.
- Back-to-back: press at B load edge k, then release, then press again at edge k+2 → capture at k+1 still occurs (one pulse). A press at k+1 instead yields no pulse and `resultado_reg` unchanged.

Source files
------------

// File: rtl/captura_operandos_if.sv
// Bus between the switch/button front-end, the operand capture block and the adder.
// The DUT uses the slave side; the environment (buttons, switches, adder) uses master.
interface captura_operandos_if #(
  parameter int unsigned n_bits = 8
);
  logic [n_bits-1:0] entrada_datos;
  logic              boton_cargar;
  logic              boton_limpiar;
  logic [n_bits-1:0] resultado_suma;
  logic [n_bits-1:0] entrada_a;
  logic [n_bits-1:0] entrada_b;
  logic [n_bits-1:0] resultado_reg;
  logic              valido;
  logic              pulso_listo;
  logic [1:0]        estado;

  modport slave (
    input  entrada_datos, boton_cargar, boton_limpiar, resultado_suma,
    output entrada_a, entrada_b, resultado_reg, valido, pulso_listo, estado
  );

  modport master (
    output entrada_datos, boton_cargar, boton_limpiar, resultado_suma,
    input  entrada_a, entrada_b, resultado_reg, valido, pulso_listo, estado
  );
endinterface

// File: rtl/captura_operandos.sv
// Sequential operand front-end: loads A then B from a shared bus on button rising
// edges, and registers the adder result once per completed pair.
module captura_operandos #(
  parameter int unsigned n_bits = 8
) (
  input logic                 clk,
  input logic                 reset,
  captura_operandos_if.slave  bus
);

  typedef enum logic [1:0] {
    ESPERA_A = 2'b00,
    ESPERA_B = 2'b01,
    LISTO    = 2'b10,
    INVALIDO = 2'b11
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [n_bits-1:0] entrada_a_q, entrada_a_d;
  logic [n_bits-1:0] entrada_b_q, entrada_b_d;
  logic [n_bits-1:0] resultado_reg_q, resultado_reg_d;
  logic              valido_q, valido_d;
  logic              pulso_listo_q, pulso_listo_d;
  logic              boton_prev_q, boton_prev_d;
  logic              capturado_q, capturado_d;
  logic              flanco;

  // State register; boton_prev resets high so a button held through reset is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q        <= ESPERA_A;
      entrada_a_q     <= '0;
      entrada_b_q     <= '0;
      resultado_reg_q <= '0;
      valido_q        <= 1'b0;
      pulso_listo_q   <= 1'b0;
      boton_prev_q    <= 1'b1;
      capturado_q     <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      entrada_a_q     <= entrada_a_d;
      entrada_b_q     <= entrada_b_d;
      resultado_reg_q <= resultado_reg_d;
      valido_q        <= valido_d;
      pulso_listo_q   <= pulso_listo_d;
      boton_prev_q    <= boton_prev_d;
      capturado_q     <= capturado_d;
    end
  end

  // Next-state and datapath; clear overrides any load edge
  always_comb begin
    estado_d        = estado_q;
    entrada_a_d     = entrada_a_q;
    entrada_b_d     = entrada_b_q;
    resultado_reg_d = resultado_reg_q;
    capturado_d     = capturado_q;
    pulso_listo_d   = 1'b0;
    boton_prev_d    = bus.boton_cargar;
    flanco          = bus.boton_cargar & ~boton_prev_q;

    if (bus.boton_limpiar) begin
      estado_d        = ESPERA_A;
      entrada_a_d     = '0;
      entrada_b_d     = '0;
      resultado_reg_d = '0;
      capturado_d     = 1'b0;
    end else begin
      case (estado_q)
        ESPERA_A: begin
          if (flanco) begin
            entrada_a_d = bus.entrada_datos;
            estado_d    = ESPERA_B;
          end
        end
        ESPERA_B: begin
          if (flanco) begin
            entrada_b_d = bus.entrada_datos;
            estado_d    = LISTO;
            capturado_d = 1'b0;
          end
        end
        LISTO: begin
          // A new load edge wins over a pending capture
          if (flanco) begin
            entrada_a_d = bus.entrada_datos;
            estado_d    = ESPERA_B;
          end else if (!capturado_q) begin
            resultado_reg_d = bus.resultado_suma;
            capturado_d     = 1'b1;
            pulso_listo_d   = 1'b1;
          end
        end
        default: estado_d = ESPERA_A;
      endcase
    end

    valido_d = (estado_d == LISTO);
  end

  assign bus.entrada_a     = entrada_a_q;
  assign bus.entrada_b     = entrada_b_q;
  assign bus.resultado_reg = resultado_reg_q;
  assign bus.valido        = valido_q;
  assign bus.pulso_listo   = pulso_listo_q;
  assign bus.estado        = 2'(estado_q);

endmodule
